// File: rtl/uart_ctrl.sv
// uart_ctrl: parametrised UART with a runtime baud divisor, RX/TX FIFOs,
// optional even/odd parity, one or two TX stop bits and sticky error flags.
// Optional feature macro: UART_LOOPBACK_EN adds a 'loopback' input that feeds
// the internal TX stream straight into the RX FSM and holds the tx pin at 1.

// Small synchronous FIFO with a first-word fall-through head.
module uart_ctrl_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign empty   = (count_reg == '0);
    assign full    = count_reg[AW];
    assign pop_ok  = pop && !empty;
    // a push into a full FIFO is only accepted when a pop frees a slot
    assign push_ok = push && (!full || pop_ok);
    // head reads back as zero while empty so stale storage never leaks out
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    // storage array, written at the tail pointer
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

module uart_ctrl #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int FIFO_AW = 4,
    parameter int DVSR_W  = 11
) (
`ifdef UART_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              clr_err,
    input  logic              rx,
    input  logic              rd_uart,
    output logic [DBIT-1:0]   rd_data,
    output logic              rx_empty,
    output logic              rx_full,
    input  logic [DBIT-1:0]   w_data,
    input  logic              wr_uart,
    output logic              tx,
    output logic              tx_full,
    output logic              tx_busy,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun_err
);
    // tick counter must reach 2*OS-1 for a double stop bit
    localparam int ST_W = $clog2(2 * OS);
    localparam int NB_W = $clog2(DBIT);

    localparam logic [ST_W-1:0] S_HALF  = ST_W'(OS / 2 - 1);
    localparam logic [ST_W-1:0] S_LAST  = ST_W'(OS - 1);
    localparam logic [ST_W-1:0] S_LAST2 = ST_W'(2 * OS - 1);
    localparam logic [NB_W-1:0] N_LAST  = NB_W'(DBIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    // ---------------- baud tick ----------------
    logic [DVSR_W-1:0] baud_cnt_reg;
    logic              tick;

    assign tick = (baud_cnt_reg == dvsr);

    // free-running divisor counter; '>=' recovers quickly if dvsr shrinks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                baud_cnt_reg <= '0;
        else if (baud_cnt_reg >= dvsr) baud_cnt_reg <= '0;
        else                         baud_cnt_reg <= baud_cnt_reg + DVSR_W'(1);
    end

    // ---------------- input synchroniser ----------------
    logic rx_meta_reg;
    logic rx_sync_reg;

    // two-flop synchroniser, idles high like the line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    logic tx_reg;
    logic rx_in;

`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_reg : rx_sync_reg;
    assign tx    = loopback ? 1'b1 : tx_reg;
`else
    assign rx_in = rx_sync_reg;
    assign tx    = tx_reg;
`endif

    // ---------------- receiver ----------------
    rx_state_t       rx_state_reg;
    logic [ST_W-1:0] rx_s_reg;
    logic [NB_W-1:0] rx_n_reg;
    logic [DBIT-1:0] rx_b_reg;
    logic [1:0]      rx_pmode_reg;
    logic            rx_pbit_reg;
    logic            rx_push_reg;
    logic            fe_set_reg;
    logic            pe_set_reg;

    // RX FSM: start detect, mid-bit sampling, stop check and push strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_reg <= RX_IDLE;
            rx_s_reg     <= '0;
            rx_n_reg     <= '0;
            rx_b_reg     <= '0;
            rx_pmode_reg <= 2'b00;
            rx_pbit_reg  <= 1'b0;
            rx_push_reg  <= 1'b0;
            fe_set_reg   <= 1'b0;
            pe_set_reg   <= 1'b0;
        end else begin
            rx_push_reg <= 1'b0;
            fe_set_reg  <= 1'b0;
            pe_set_reg  <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_in) begin
                        rx_state_reg <= RX_START;
                        rx_s_reg     <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_s_reg == S_HALF) begin
                            rx_s_reg <= '0;
                            if (rx_in) begin
                                rx_state_reg <= RX_IDLE;   // glitch, not a start bit
                            end else begin
                                rx_state_reg <= RX_DATA;
                                rx_n_reg     <= '0;
                                rx_pmode_reg <= parity_mode;
                            end
                        end else begin
                            rx_s_reg <= rx_s_reg + ST_W'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_s_reg == S_LAST) begin
                            rx_s_reg <= '0;
                            rx_b_reg <= {rx_in, rx_b_reg[DBIT-1:1]};
                            if (rx_n_reg == N_LAST) begin
                                rx_state_reg <= parity_on(rx_pmode_reg) ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_n_reg <= rx_n_reg + NB_W'(1);
                            end
                        end else begin
                            rx_s_reg <= rx_s_reg + ST_W'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick) begin
                        if (rx_s_reg == S_LAST) begin
                            rx_s_reg     <= '0;
                            rx_pbit_reg  <= rx_in;
                            rx_state_reg <= RX_STOP;
                        end else begin
                            rx_s_reg <= rx_s_reg + ST_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_s_reg == S_LAST) begin
                            rx_s_reg     <= '0;
                            rx_state_reg <= RX_IDLE;
                            rx_push_reg  <= 1'b1;
                            fe_set_reg   <= !rx_in;
                            pe_set_reg   <= parity_on(rx_pmode_reg) &&
                                            (rx_pbit_reg != ((^rx_b_reg) ^ (rx_pmode_reg == 2'b10)));
                        end else begin
                            rx_s_reg <= rx_s_reg + ST_W'(1);
                        end
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    uart_ctrl_fifo #(.DW(DBIT), .AW(FIFO_AW)) rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push_reg),
        .pop     (rd_uart),
        .din     (rx_b_reg),
        .dout    (rd_data),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    // ---------------- sticky errors ----------------
    logic frame_err_reg;
    logic parity_err_reg;
    logic overrun_err_reg;
    logic ovr_set;

    // a byte is lost only if the FIFO is full and nothing is popped that cycle
    assign ovr_set = rx_push_reg && rx_full && !rd_uart;

    // sticky flags; a set in the same cycle wins over clr_err
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_reg   <= 1'b0;
            parity_err_reg  <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            frame_err_reg   <= fe_set_reg | (frame_err_reg   & ~clr_err);
            parity_err_reg  <= pe_set_reg | (parity_err_reg  & ~clr_err);
            overrun_err_reg <= ovr_set    | (overrun_err_reg & ~clr_err);
        end
    end

    assign frame_err   = frame_err_reg;
    assign parity_err  = parity_err_reg;
    assign overrun_err = overrun_err_reg;

    // ---------------- transmitter ----------------
    tx_state_t       tx_state_reg;
    logic [ST_W-1:0] tx_s_reg;
    logic [NB_W-1:0] tx_n_reg;
    logic [DBIT-1:0] tx_b_reg;
    logic [1:0]      tx_pmode_reg;
    logic            tx_stop2_reg;
    logic            tx_pbit_reg;
    logic            tx_empty;
    logic [DBIT-1:0] tx_head;
    logic            tx_stop_done;
    logic            tx_load;

    assign tx_stop_done = (tx_state_reg == TX_STOP) && tick &&
                          (tx_s_reg == (tx_stop2_reg ? S_LAST2 : S_LAST));
    // loading straight from the end of a stop bit keeps frames back-to-back
    assign tx_load = !tx_empty && ((tx_state_reg == TX_IDLE) || tx_stop_done);
    assign tx_busy = (tx_state_reg != TX_IDLE) || !tx_empty;

    uart_ctrl_fifo #(.DW(DBIT), .AW(FIFO_AW)) tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_uart),
        .pop     (tx_load),
        .din     (w_data),
        .dout    (tx_head),
        .empty   (tx_empty),
        .full    (tx_full)
    );

    // TX FSM: shifts start, data, optional parity and stop bits onto tx_reg
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= TX_IDLE;
            tx_s_reg     <= '0;
            tx_n_reg     <= '0;
            tx_b_reg     <= '0;
            tx_pmode_reg <= 2'b00;
            tx_stop2_reg <= 1'b0;
            tx_pbit_reg  <= 1'b0;
            tx_reg       <= 1'b1;
        end else if (tx_load) begin
            tx_state_reg <= TX_START;
            tx_s_reg     <= '0;
            tx_b_reg     <= tx_head;
            tx_pmode_reg <= parity_mode;
            tx_stop2_reg <= stop2;
            tx_pbit_reg  <= (^tx_head) ^ (parity_mode == 2'b10);
            tx_reg       <= 1'b0;
        end else begin
            case (tx_state_reg)
                TX_IDLE: tx_reg <= 1'b1;
                TX_START: begin
                    if (tick) begin
                        if (tx_s_reg == S_LAST) begin
                            tx_s_reg     <= '0;
                            tx_n_reg     <= '0;
                            tx_state_reg <= TX_DATA;
                            tx_reg       <= tx_b_reg[0];
                        end else begin
                            tx_s_reg <= tx_s_reg + ST_W'(1);
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_s_reg == S_LAST) begin
                            tx_s_reg <= '0;
                            tx_b_reg <= tx_b_reg >> 1;
                            if (tx_n_reg == N_LAST) begin
                                if (parity_on(tx_pmode_reg)) begin
                                    tx_state_reg <= TX_PARITY;
                                    tx_reg       <= tx_pbit_reg;
                                end else begin
                                    tx_state_reg <= TX_STOP;
                                    tx_reg       <= 1'b1;
                                end
                            end else begin
                                tx_n_reg <= tx_n_reg + NB_W'(1);
                                tx_reg   <= tx_b_reg[1];
                            end
                        end else begin
                            tx_s_reg <= tx_s_reg + ST_W'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        if (tx_s_reg == S_LAST) begin
                            tx_s_reg     <= '0;
                            tx_state_reg <= TX_STOP;
                            tx_reg       <= 1'b1;
                        end else begin
                            tx_s_reg <= tx_s_reg + ST_W'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_stop_done) begin
                        tx_s_reg     <= '0;
                        tx_state_reg <= TX_IDLE;
                    end else if (tick) begin
                        tx_s_reg <= tx_s_reg + ST_W'(1);
                    end
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: reset, TX bit timing, RX parity/frame/
// overrun errors, TX->RX external loop (odd parity, two stop bits) and, when
// UART_LOOPBACK_EN is defined, the internal loopback path.
module tb_uart_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] dvsr;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        clr_err;
    logic        rd_uart;
    logic [7:0]  rd_data;
    logic        rx_empty, rx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        tx_pin, tx_full, tx_busy;
    logic        frame_err, parity_err, overrun_err;
    logic        rx_drv;
    logic        ext_loop;
    logic        rx_pin;
`ifdef UART_LOOPBACK_EN
    logic        loopback;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    logic       tx_bit_q[$];

    assign rx_pin = ext_loop ? tx_pin : rx_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_ctrl #(.DBIT(8), .OS(16), .FIFO_AW(4), .DVSR_W(11)) dut (
`ifdef UART_LOOPBACK_EN
        .loopback    (loopback),
`endif
        .clk         (clk),
        .reset_n     (reset_n),
        .dvsr        (dvsr),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .clr_err     (clr_err),
        .rx          (rx_pin),
        .rd_uart     (rd_uart),
        .rd_data     (rd_data),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .w_data      (w_data),
        .wr_uart     (wr_uart),
        .tx          (tx_pin),
        .tx_full     (tx_full),
        .tx_busy     (tx_busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] d);
        w_data  = d;
        wr_uart = 1'b1;
        wait_clks(1);
        wr_uart = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_clks(1);
        clr_err = 1'b0;
    endtask

    // pops the scoreboard and compares against the FIFO head, then pops the FIFO
    task automatic read_rx(input string tag);
        logic [7:0] e;
        check({tag, "_avail"}, rx_empty, 1'b0);
        check({tag, "_sb"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, rd_data, e);
            $display("rx read %s: 0x%02h (expected 0x%02h)", tag, rd_data, e);
        end
        rd_uart = 1'b1;
        wait_clks(1);
        rd_uart = 1'b0;
    endtask

    // drives one frame on the rx pin; a bad stop bit is held only past mid-bit
    task automatic send_rx(input logic [7:0] d, input logic par_en, input logic par_v,
                           input logic stop_v);
        int bc;
        bc = 16 * (int'(dvsr) + 1);
        $display("rx drive: data 0x%02h par_en %0d par %0d stop %0d", d, par_en, par_v, stop_v);
        rx_drv = 1'b0;
        wait_clks(bc);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            wait_clks(bc);
        end
        if (par_en) begin
            rx_drv = par_v;
            wait_clks(bc);
        end
        rx_drv = stop_v;
        if (stop_v) wait_clks(bc);
        else        wait_clks(bc / 2 + 20);
        rx_drv = 1'b1;
        wait_clks(2 * bc);
    endtask

    task automatic wait_tx_fall(input int max, output logic ok);
        logic prev;
        prev = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (prev && !tx_pin) ok = 1'b1;
            prev = tx_pin;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx"},       tx_pin,      1'b1);
        check({tag, "_rx_empty"}, rx_empty,    1'b1);
        check({tag, "_rx_full"},  rx_full,     1'b0);
        check({tag, "_tx_full"},  tx_full,     1'b0);
        check({tag, "_tx_busy"},  tx_busy,     1'b0);
        check({tag, "_ferr"},     frame_err,   1'b0);
        check({tag, "_perr"},     parity_err,  1'b0);
        check({tag, "_oerr"},     overrun_err, 1'b0);
        check({tag, "_rd_data"},  rd_data,     8'h00);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic [7:0]  d;
        int          t0;
        int          nf;
        int          falls[3];
        logic        prev;

        reset_n = 1'b0; dvsr = 11'd26; parity_mode = 2'b00; stop2 = 1'b0;
        clr_err = 1'b0; rd_uart = 1'b0; w_data = 8'h00; wr_uart = 1'b0;
        rx_drv = 1'b1; ext_loop = 1'b0;
`ifdef UART_LOOPBACK_EN
        loopback = 1'b0;
`endif
        wait_clks(4);
        check_reset_state("por");
        reset_n = 1'b1;
        wait_clks(3);

        // ---- 8N1 transmit of 0xA5 at dvsr=26 ----
        d = 8'hA5;
        tx_bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_bit_q.push_back(d[i]);
        tx_bit_q.push_back(1'b1);
        write_tx(d);
        wait_tx_fall(100, ok);
        check("t2_start_seen", ok, 1'b1);
        wait_clks(216);
        for (int k = 0; k < 10; k++) begin
            logic e;
            e = tx_bit_q.pop_front();
            check($sformatf("t2_bit%0d", k), tx_pin, e);
            $display("tx bit %0d: %0d (expected %0d)", k, tx_pin, e);
            if (k < 9) wait_clks(432);
        end
        check("t2_busy_mid_stop", tx_busy, 1'b1);
        t0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!tx_busy) ok = 1'b1;
        end
        check("t2_busy_drop", ok, 1'b1);
        check("t2_busy_drop_time", ((cyc - t0) >= 180) && ((cyc - t0) <= 230), 1'b1);
        check("t2_tx_idle", tx_pin, 1'b1);

        // ---- fill TX FIFO, then reset mid-frame ----
        for (int i = 0; i < 17; i++) write_tx((i == 0) ? 8'h5A : 8'(i));
        check("t1_tx_full", tx_full, 1'b1);
        wait_clks(683);
        check("t1_busy_before", tx_busy, 1'b1);
        check("t1_tx_bit0_low", tx_pin, 1'b0);
        reset_n = 1'b0;
        #1;
        $display("reset asserted mid-frame");
        check_reset_state("t1");
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(3);

        // ---- RX even parity, good then bad ----
        dvsr = 11'd3;
        parity_mode = 2'b01;
        d = 8'h3C;
        exp_q.push_back(d);
        send_rx(d, 1'b1, ^d, 1'b1);
        check("t3a_perr", parity_err, 1'b0);
        check("t3a_ferr", frame_err, 1'b0);
        read_rx("t3a");
        exp_q.push_back(d);
        send_rx(d, 1'b1, ~(^d), 1'b1);
        check("t3b_perr", parity_err, 1'b1);
        read_rx("t3b");
        pulse_clr();
        check("t3_perr_cleared", parity_err, 1'b0);

        // ---- RX frame error ----
        parity_mode = 2'b00;
        exp_q.push_back(8'h55);
        send_rx(8'h55, 1'b0, 1'b0, 1'b0);
        check("t4_ferr", frame_err, 1'b1);
        check("t4_perr", parity_err, 1'b0);
        read_rx("t4");
        check("t4_empty_after", rx_empty, 1'b1);
        pulse_clr();
        check("t4_ferr_cleared", frame_err, 1'b0);

        // ---- RX overrun: 17 frames into a 16-deep FIFO ----
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_rx(8'(i), 1'b0, 1'b0, 1'b1);
        end
        check("t5_rx_full", rx_full, 1'b1);
        check("t5_oerr", overrun_err, 1'b1);
        for (int i = 0; i < 16; i++) read_rx($sformatf("t5_%0d", i));
        check("t5_rx_empty", rx_empty, 1'b1);
        pulse_clr();
        check("t5_oerr_cleared", overrun_err, 1'b0);

        // ---- external TX->RX loop, odd parity, two stop bits ----
        parity_mode = 2'b10;
        stop2 = 1'b1;
        ext_loop = 1'b1;
        wait_clks(4);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h81);
        write_tx(8'h00); write_tx(8'hFF); write_tx(8'h81);
        nf = 0;
        prev = 1'b1;
        for (int i = 0; i < 3000 && nf < 3; i++) begin
            @(negedge clk);
            if (prev && !tx_pin) begin
                falls[nf] = cyc;
                nf++;
            end
            prev = tx_pin;
        end
        check("loop_falls", nf, 3);
        if (nf == 3) check("loop_frame_len", falls[2] - falls[1], 768);
        wait_clks(900);
        check("loop_busy", tx_busy, 1'b0);
        check("loop_ferr", frame_err, 1'b0);
        check("loop_perr", parity_err, 1'b0);
        check("loop_oerr", overrun_err, 1'b0);
        for (int i = 0; i < 3; i++) read_rx($sformatf("loop_%0d", i));
        check("loop_empty_after", rx_empty, 1'b1);
        ext_loop = 1'b0;

`ifdef UART_LOOPBACK_EN
        // ---- internal loopback: pin tx must stay high ----
        loopback = 1'b1;
        wait_clks(4);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h81);
        write_tx(8'h00); write_tx(8'hFF); write_tx(8'h81);
        nf = 0;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (!tx_pin) nf++;
        end
        check("t6_pin_low_cycles", nf, 0);
        check("t6_busy", tx_busy, 1'b0);
        check("t6_ferr", frame_err, 1'b0);
        check("t6_perr", parity_err, 1'b0);
        check("t6_oerr", overrun_err, 1'b0);
        for (int i = 0; i < 3; i++) read_rx($sformatf("t6_%0d", i));
        loopback = 1'b0;
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
